// File: rtl/array_index_engine_if.sv
// Request/response bundle for the array index engine: heap write port,
// search request and search completion.
interface array_index_engine_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          wrEnable;
  logic [MemoryElementWidth-1:0] wrArray;
  logic [MemoryElementWidth-1:0] wrIndex;
  logic [MemoryElementWidth-1:0] wrData;
  logic                          start;
  logic [MemoryElementWidth-1:0] array;
  logic [MemoryElementWidth-1:0] size;
  logic [MemoryElementWidth-1:0] key;
  logic [1:0]                    mode;
  logic                          ready;
  logic                          done;
  logic [MemoryElementWidth-1:0] result;
  logic                          error;

  modport master (
    output wrEnable, wrArray, wrIndex, wrData, start, array, size, key, mode,
    input  ready, done, result, error
  );

  modport slave (
    input  wrEnable, wrArray, wrIndex, wrData, start, array, size, key, mode,
    output ready, done, result, error
  );
endinterface

// File: rtl/array_index_engine.sv
// Linear search engine over a heap of fixed-size arrays: first/last equal
// index or less/greater count, one element compared per cycle.
module array_index_engine #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 10,
  parameter int NArrays            = 20
) (
  input  logic                 clock,
  input  logic                 reset,
  array_index_engine_if.slave  bus
);
  localparam int W     = MemoryElementWidth;
  localparam int Depth = NArrays * NArea;
  localparam int AW    = $clog2(Depth);
  localparam int IW    = $clog2(NArea + 1);

  typedef enum logic [1:0] {Idle, Scan, Done} state_t;

  state_t         state, nextState;
  logic [W-1:0]   heap [Depth];

  logic [AW-1:0]  base;
  logic [IW-1:0]  idx, effSize;
  logic [W-1:0]   keyQ, acc, newAcc, resultQ;
  logic [1:0]     modeQ;
  logic           errorQ;

  logic           badArray, hit, scanEnd;
  logic [IW-1:0]  reqSize;
  logic [W-1:0]   elem;

  assign badArray = bus.array >= W'(NArrays);
  assign reqSize  = (bus.size >= W'(NArea)) ? IW'(NArea) : bus.size[IW-1:0];
  // Combinational read: a write landing on this edge is not yet visible.
  assign elem     = heap[base + AW'(idx)];
  assign hit      = elem == keyQ;
  assign scanEnd  = (idx == effSize - IW'(1)) || (modeQ == 2'd0 && hit);

  // Heap is never reset; out-of-range writes are dropped.
  always_ff @(posedge clock)
    if (bus.wrEnable && bus.wrArray < W'(NArrays) && bus.wrIndex < W'(NArea))
      heap[AW'(bus.wrArray) * AW'(NArea) + AW'(bus.wrIndex)] <= bus.wrData;

  // Accumulator holds "last match index + 1" for equality modes, count otherwise.
  always_comb begin
    newAcc = acc;
    case (modeQ)
      2'd0, 2'd1: if (hit)         newAcc = W'(idx) + W'(1);
      2'd2:       if (elem < keyQ) newAcc = acc + W'(1);
      default:    if (elem > keyQ) newAcc = acc + W'(1);
    endcase
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= Idle;
    else        state <= nextState;

  always_comb begin
    nextState = state;
    case (state)
      Idle: if (bus.start)
              nextState = (badArray || reqSize == '0) ? Done : Scan;
      Scan: if (scanEnd) nextState = Done;
      default: nextState = Idle;
    endcase
  end

  always_comb begin
    bus.ready = (state == Idle);
    bus.done  = (state == Done);
  end

  assign bus.result = resultQ;
  assign bus.error  = errorQ;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      base    <= '0;
      idx     <= '0;
      effSize <= '0;
      keyQ    <= '0;
      modeQ   <= '0;
      acc     <= '0;
      resultQ <= '0;
      errorQ  <= 1'b0;
    end else begin
      case (state)
        Idle: if (bus.start) begin
          base    <= AW'(bus.array) * AW'(NArea);
          effSize <= reqSize;
          keyQ    <= bus.key;
          modeQ   <= bus.mode;
          idx     <= '0;
          acc     <= '0;
          if (badArray || reqSize == '0) begin
            resultQ <= '0;
            errorQ  <= badArray;
          end
        end
        Scan: begin
          idx <= idx + IW'(1);
          acc <= newAcc;
          if (scanEnd) begin
            resultQ <= newAcc;
            errorQ  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
endmodule
